// File: rtl/mix_round_engine_if.sv
`timescale 1ns/1ps
// mix_round_engine_if
//   Handshake bundle for mix_round_engine.
//   Input side : in_valid / in_ready / in_data carry a seed vector into the engine.
//   Output side: out_valid / out_ready / out_data carry the mixed state out.
//   busy       : engine is running a job or holding a result.
//   Lane packing on both vectors: lane i = bits [i*WIDTH +: WIDTH].
//   modport slave  : the engine side.
//   modport master : the producer/consumer side (e.g. a bench).
interface mix_round_engine_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*WIDTH-1:0]   in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*WIDTH-1:0]   out_data;
   logic                     busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/mix_round_engine.sv
`timescale 1ns/1ps
// mix_round_engine
//   Multi-lane arithmetic mixing engine. Loads LANES seed words, applies
//   ROUNDS mixing rounds (one per clock) and holds the mixed state behind a
//   valid/ready output handshake until it is taken.
//   Ports:
//     clk   - clock, all state updates on posedge
//     rst_n - asynchronous active-low reset
//     bus   - mix_round_engine_if.slave: in_valid/in_ready/in_data seed
//             input, out_valid/out_ready/out_data result output, busy
//   Each round: step A adds the previous lane (ring order) plus the lane
//   index, step B XORs in the opposite lane shifted left by SHIFT. Both
//   steps walk the lanes in order and reuse values already updated in the
//   same round.
module mix_round_engine #(
   parameter int WIDTH  = 32,
   parameter int LANES  = 8,
   parameter int ROUNDS = 4,
   parameter int SHIFT  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   mix_round_engine_if.slave  bus
);

   localparam int VEC_W = LANES * WIDTH;
   localparam int HALF  = LANES / 2;
   localparam int CNT_W = $clog2(ROUNDS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [VEC_W-1:0]    lanes_r;
   logic [VEC_W-1:0]    round_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                out_valid_r;
   logic                busy_r;
   logic                in_ready_r;

   // One full mixing round over the packed lane vector.
   function automatic logic [VEC_W-1:0] mix_round(input logic [VEC_W-1:0] st);
      logic [WIDTH-1:0] t [LANES];
      logic [VEC_W-1:0] res;
      for (int i = 0; i < LANES; i++) begin
         t[i] = st[i*WIDTH +: WIDTH];
      end
      // Lane 0 reads the last lane before it is touched this round.
      for (int i = 0; i < LANES; i++) begin
         t[i] = t[i] + t[(i + LANES - 1) % LANES] + WIDTH'(i);
      end
      // Lower half sees step-A values of the upper half; the upper half then
      // sees the already XOR-updated lower half.
      for (int i = 0; i < LANES; i++) begin
         t[i] = t[i] ^ (t[(i + HALF) % LANES] << SHIFT);
      end
      res = {VEC_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         res[i*WIDTH +: WIDTH] = t[i];
      end
      return res;
   endfunction

   // Combinational round applied to the current lane state.
   always_comb begin
      round_s = mix_round(lanes_r);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_W'(ROUNDS - 1)) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            // in_valid is not looked at here: the handshake cycle never
            // accepts a new seed.
            if (bus.out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Lane state and round counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes_r <= {VEC_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  lanes_r <= bus.in_data;
                  cnt_r   <= {CNT_W{1'b0}};
               end
            end
            ST_RUN: begin
               lanes_r <= round_s;
               cnt_r   <= cnt_r + CNT_W'(1);
            end
            default: begin
               lanes_r <= lanes_r;
               cnt_r   <= cnt_r;
            end
         endcase
      end
   end

   // Status flags registered from the next state so they line up with state_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         out_valid_r <= (state_s == ST_DONE);
         busy_r      <= (state_s != ST_IDLE);
         in_ready_r  <= (state_s == ST_IDLE);
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = lanes_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mix_round_engine.sv
`timescale 1ns/1ps
// tb_mix_round_engine
//   Three engine instances: default parameters, a minimal 8-bit 2-lane
//   single-round build, and a default-width single-round build. Expected
//   results are queued when a seed is accepted and popped when the result
//   handshake happens.
module tb_mix_round_engine;

   localparam int D_W = 32;
   localparam int D_L = 8;
   localparam int D_V = D_W * D_L;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [D_V-1:0] exp_q   [$];
   logic [D_V-1:0] exp_r_q [$];
   logic [15:0]    exp_s_q [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mix_round_engine_if #(.WIDTH(32), .LANES(8)) bus_d ();
   mix_round_engine_if #(.WIDTH(8),  .LANES(2)) bus_s ();
   mix_round_engine_if #(.WIDTH(32), .LANES(8)) bus_r ();

   mix_round_engine #(.WIDTH(32), .LANES(8), .ROUNDS(4), .SHIFT(16)) u_dut_def (
      .clk(clk), .rst_n(rst_n), .bus(bus_d));
   mix_round_engine #(.WIDTH(8), .LANES(2), .ROUNDS(1), .SHIFT(4)) u_dut_small (
      .clk(clk), .rst_n(rst_n), .bus(bus_s));
   mix_round_engine #(.WIDTH(32), .LANES(8), .ROUNDS(1), .SHIFT(16)) u_dut_r1 (
      .clk(clk), .rst_n(rst_n), .bus(bus_r));

   // Reference: 8 lanes of 32 bits, shift 16, written step by step.
   function automatic logic [D_V-1:0] ref_mix(input logic [D_V-1:0] seed, input int rounds);
      logic [31:0] s [8];
      logic [31:0] a [8];
      logic [31:0] b [8];
      logic [D_V-1:0] res;
      for (int i = 0; i < 8; i++) s[i] = seed[32*i +: 32];
      for (int r = 0; r < rounds; r++) begin
         a[0] = s[0] + s[7];
         for (int i = 1; i < 8; i++) a[i] = s[i] + a[i-1] + 32'(i);
         for (int i = 0; i < 4; i++) b[i] = a[i] ^ (a[i+4] << 16);
         for (int i = 4; i < 8; i++) b[i] = a[i] ^ (b[i-4] << 16);
         s = b;
      end
      for (int i = 0; i < 8; i++) res[32*i +: 32] = s[i];
      return res;
   endfunction

   function automatic logic [D_V-1:0] rand_vec();
      logic [D_V-1:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus_d.out_valid !== 1'b0 || bus_d.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold out_valid=%b busy=%b required 0 0", bus_d.out_valid, bus_d.busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_d.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b required 1", bus_d.in_ready);
      end
      checks++;
      if (bus_d.out_data !== {D_V{1'b0}}) begin
         errors++;
         $display("FAIL reset_out_data got %h required 0", bus_d.out_data);
      end
      checks++;
      if (bus_s.in_ready !== 1'b1 || bus_s.out_valid !== 1'b0 || bus_r.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_other_duts small_ready=%b small_valid=%b r1_valid=%b required 1 0 0",
                  bus_s.in_ready, bus_s.out_valid, bus_r.out_valid);
      end
   endtask

   task automatic test_minimal();
      logic [15:0] exp;
      checks++;
      if (bus_s.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL minimal_ready got %b required 1", bus_s.in_ready);
      end
      bus_s.in_data  = 16'h0201;
      bus_s.in_valid = 1'b1;
      exp_s_q.push_back(16'h3663);
      @(negedge clk);
      bus_s.in_valid = 1'b0;
      checks++;
      if (bus_s.out_valid !== 1'b0 || bus_s.busy !== 1'b1) begin
         errors++;
         $display("FAIL minimal_run out_valid=%b busy=%b required 0 1", bus_s.out_valid, bus_s.busy);
      end
      @(negedge clk);
      checks++;
      if (bus_s.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL minimal_latency out_valid=%b required 1", bus_s.out_valid);
      end else begin
         exp = exp_s_q.pop_front();
         checks++;
         if (bus_s.out_data !== exp) begin
            errors++;
            $display("FAIL minimal_data got %h required %h", bus_s.out_data, exp);
         end
      end
      bus_s.out_ready = 1'b1;
      @(negedge clk);
      bus_s.out_ready = 1'b0;
      checks++;
      if (bus_s.out_valid !== 1'b0 || bus_s.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL minimal_return out_valid=%b in_ready=%b required 0 1", bus_s.out_valid, bus_s.in_ready);
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      logic [15:0] exp;
      bus_s.in_data  = 16'hFFFF;
      bus_s.in_valid = 1'b1;
      bus_s.out_ready = 1'b1;
      exp_s_q.push_back(16'h1E1E);
      @(negedge clk);
      bus_s.in_valid = 1'b0;
      while (bus_s.out_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 10) begin
         errors++;
         $display("FAIL wrap_timeout out_valid=%b required 1", bus_s.out_valid);
      end else begin
         exp = exp_s_q.pop_front();
         if (bus_s.out_data !== exp) begin
            errors++;
            $display("FAIL wrap_data got %h required %h", bus_s.out_data, exp);
         end
      end
      @(negedge clk);
      bus_s.out_ready = 1'b0;
   endtask

   task automatic test_zero_seed();
      int n = 0;
      logic [D_V-1:0] exp;
      bus_r.in_data  = {D_V{1'b0}};
      bus_r.in_valid = 1'b1;
      bus_r.out_ready = 1'b0;
      exp_r_q.push_back(ref_mix({D_V{1'b0}}, 1));
      @(negedge clk);
      bus_r.in_valid = 1'b0;
      while (bus_r.out_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 10) begin
         errors++;
         $display("FAIL zero_timeout out_valid=%b required 1", bus_r.out_valid);
      end else begin
         exp = exp_r_q.pop_front();
         if (bus_r.out_data !== exp) begin
            errors++;
            $display("FAIL zero_full got %h required %h", bus_r.out_data, exp);
         end
         checks++;
         if (bus_r.out_data[0*32 +: 32] !== 32'h000A0000 || bus_r.out_data[3*32 +: 32] !== 32'h001C0006) begin
            errors++;
            $display("FAIL zero_lanes03 got %h %h required 000a0000 001c0006",
                     bus_r.out_data[0*32 +: 32], bus_r.out_data[3*32 +: 32]);
         end
         checks++;
         if (bus_r.out_data[4*32 +: 32] !== 32'h0000000A || bus_r.out_data[7*32 +: 32] !== 32'h0006001C) begin
            errors++;
            $display("FAIL zero_lanes47 got %h %h required 0000000a 0006001c",
                     bus_r.out_data[4*32 +: 32], bus_r.out_data[7*32 +: 32]);
         end
      end
      bus_r.out_ready = 1'b1;
      @(negedge clk);
      bus_r.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n = 0;
      int stray = 0;
      logic [D_V-1:0] seed;
      logic [D_V-1:0] exp;
      seed = rand_vec();
      bus_d.in_data   = seed;
      bus_d.in_valid  = 1'b1;
      bus_d.out_ready = 1'b0;
      exp_q.push_back(ref_mix(seed, 4));
      @(negedge clk);
      bus_d.in_valid = 1'b0;
      while (bus_d.out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL bp_timeout out_valid=%b required 1", bus_d.out_valid);
      end
      exp = exp_q.pop_front();
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (bus_d.out_data !== exp || bus_d.out_valid !== 1'b1 || bus_d.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d data=%h valid=%b ready=%b required %h 1 0",
                     c, bus_d.out_data, bus_d.out_valid, bus_d.in_ready, exp);
         end
         bus_d.in_valid = (c % 2 == 0);
         bus_d.in_data  = ~seed;
         @(negedge clk);
      end
      bus_d.in_valid  = 1'b0;
      bus_d.out_ready = 1'b1;
      checks++;
      if (bus_d.out_data !== exp) begin
         errors++;
         $display("FAIL bp_final_data got %h required %h", bus_d.out_data, exp);
      end
      @(negedge clk);
      bus_d.out_ready = 1'b0;
      checks++;
      if (bus_d.out_valid !== 1'b0 || bus_d.in_ready !== 1'b1 || bus_d.busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_return valid=%b ready=%b busy=%b required 0 1 0",
                  bus_d.out_valid, bus_d.in_ready, bus_d.busy);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus_d.out_valid !== 1'b0 || bus_d.busy !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL bp_dropped_pulses got %0d active cycles required 0", stray);
      end
   endtask

   task automatic test_back_to_back();
      int acc [$];
      int got = 0;
      int n = 0;
      bit upd;
      logic [D_V-1:0] exp;
      bus_d.in_data   = rand_vec();
      bus_d.in_valid  = 1'b1;
      bus_d.out_ready = 1'b1;
      while (got < 4 && n < 80) begin
         upd = 1'b0;
         if (bus_d.in_ready === 1'b1) begin
            exp_q.push_back(ref_mix(bus_d.in_data, 4));
            acc.push_back(cyc);
            upd = 1'b1;
         end
         if (bus_d.out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_unexpected got %h required no output", bus_d.out_data);
            end else begin
               exp = exp_q.pop_front();
               if (bus_d.out_data !== exp) begin
                  errors++;
                  $display("FAIL b2b_data job %0d got %h required %h", got, bus_d.out_data, exp);
               end
            end
            got++;
         end
         @(negedge clk);
         n++;
         if (upd) bus_d.in_data = rand_vec();
      end
      bus_d.in_valid  = 1'b0;
      bus_d.out_ready = 1'b0;
      checks++;
      if (got != 4) begin
         errors++;
         $display("FAIL b2b_timeout got %0d results required 4", got);
      end
      for (int k = 1; k < acc.size(); k++) begin
         checks++;
         if (acc[k] - acc[k-1] != 6) begin
            errors++;
            $display("FAIL b2b_spacing job %0d got %0d cycles required 6", k, acc[k] - acc[k-1]);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_leftover got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_run();
      int stray = 0;
      bus_d.in_data  = rand_vec();
      bus_d.in_valid = 1'b1;
      @(negedge clk);
      bus_d.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_d.busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_busy got %b required 1", bus_d.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_d.out_valid !== 1'b0 || bus_d.busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_async valid=%b busy=%b required 0 0", bus_d.out_valid, bus_d.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_d.in_ready !== 1'b1 || bus_d.out_data !== {D_V{1'b0}} || bus_d.busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_release ready=%b busy=%b data=%h required 1 0 0",
                  bus_d.in_ready, bus_d.busy, bus_d.out_data);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_d.out_valid !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL midrun_no_result got %0d valid cycles required 0", stray);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus_d.in_valid = 1'b0; bus_d.out_ready = 1'b0; bus_d.in_data = {D_V{1'b0}};
      bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b0; bus_s.in_data = 16'h0000;
      bus_r.in_valid = 1'b0; bus_r.out_ready = 1'b0; bus_r.in_data = {D_V{1'b0}};
      test_reset();
      test_minimal();
      test_wrap();
      test_zero_seed();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mix_round_engine.md
Name: mix_round_engine

Overview:
- Parametrised multi-lane arithmetic mixing engine. Loads LANES seed words, applies ROUNDS mixing rounds at one round per clock, and presents the mixed state behind a valid/ready output handshake.
- Generalises the fixed 8x32-bit free-running mixer to configurable width, lane count, round count and shift amount.
- Adds start/done control and output backpressure.
- Serves as the compute kernel for the team's synthetic-load and stress benches.

Parameters:
WIDTH, 32, lane word width in bits (>=4)
LANES, 8, number of state lanes (even, >=2)
ROUNDS, 4, mixing rounds per job (>=1)
SHIFT, 16, left-shift amount used in the XOR step (0 < SHIFT < WIDTH)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  seed vector valid
in_ready  output  1  engine idle, seed accepted this cycle if in_valid
in_data  input  LANES*WIDTH  seed vector; lane i = bits [i*WIDTH +: WIDTH]
out_valid  output  1  mixed result available
out_ready  input  1  consumer accepts result
out_data  output  LANES*WIDTH  mixed state, same lane packing
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release on clk): state=IDLE, all lane registers s[i]=0, round counter=0, out_valid=0, busy=0. in_ready=1 once reset is released. Asserting reset at any point, including mid-RUN or in DONE, discards the job with no output.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid=1 at a posedge, s[i] <= in_data lane i, counter <= 0, next state RUN.
- RUN: in_ready=0. Each posedge applies one round to s[], then counter <= counter+1. After the round with counter==ROUNDS-1, next state is DONE. in_valid is ignored.
- DONE: out_valid=1 and out_data=s. Both are held stable until out_valid&&out_ready at a posedge, then next state is IDLE. in_ready=0 in DONE, so a new seed cannot be accepted in the same cycle as the output handshake.
- Latency: seed accepted at edge k gives out_valid high after edge k+ROUNDS. With out_ready tied high, the minimum job spacing is ROUNDS+2 cycles.
- Round function is a combinational chain in lane order. Every later step uses values already updated earlier in the same round. All arithmetic is modulo 2^WIDTH and unsigned.
- Step A, for i = 0..LANES-1: s[i] = s[i] + s[(i+LANES-1) mod LANES] + i. For i=0 the operand s[LANES-1] is its pre-round value.
- Step B, for i = 0..LANES-1: s[i] = s[i] ^ ((s[(i+LANES/2) mod LANES] << SHIFT) truncated to WIDTH). For i < LANES/2 the operand is the step-A value; for i >= LANES/2 it is the step-B-updated value.
- The lane constant i is truncated to WIDTH bits.
- Counter width is clog2(ROUNDS+1).
- Simultaneous in_valid and out_ready in DONE: only the output handshake occurs.
- out_data is also driven as s in IDLE and RUN, but it is valid only while out_valid=1.

Test Plan:
- Reset mid-RUN: default params, assert rst_n=0 two cycles into a job -> out_valid=0, busy=0, in_ready=1 after release, out_data=0, and no result is ever produced for the aborted job.
- Minimal config WIDTH=8, LANES=2, SHIFT=4, ROUNDS=1, seed lane0=0x01, lane1=0x02 -> out_valid rises exactly 1 cycle after acceptance; out_data=0x3663 (lane0=0x63, lane1=0x36).
- Defaults with an all-zero seed, ROUNDS=1 -> lane0=0x000A0000, lane3=0x001C0006, lane4=0x0000000A, lane7=0x0006001C.
- Backpressure: default params, out_ready held 0 for 10 cycles after out_valid -> out_data stable and in_ready=0 throughout; in_valid pulses during this window are dropped; the handshake on the 11th cycle returns the engine to IDLE.
- Back-to-back jobs with out_ready=1 and in_valid=1 continuously, ROUNDS=4 -> seeds accepted every 6 cycles; each result matches the reference model for its own seed.
- Wrap-around: WIDTH=8, LANES=2, ROUNDS=1, SHIFT=4, seed lane0=0xFF, lane1=0xFF -> step A gives 0xFE, 0xFE; final lane0=0xFE^0xE0=0x1E, lane1=0xFE^0xE0=0x1E; out_data=0x1E1E.
